// File: rtl/sirv_tl_frag_sequencer.sv
// Fragment sequencer for a TileLink A/D channel pair feeding an 8-bit slave.
// A multi-byte request from the upstream repeater becomes 2^min(size,6)
// single-byte fragments. Get requests are replayed by the repeater
// (io_repeat), while Puts supply one upstream beat per fragment. On the
// D side, every Get response is forwarded. For a Put, all acks except the
// last are dropped.
module sirv_tl_frag_sequencer (
  input  logic        clock,
  input  logic        reset,

  output logic        io_repeat,

  output logic        io_in_a_ready,
  input  logic        io_in_a_valid,
  input  logic [2:0]  io_in_a_bits_opcode,
  input  logic [2:0]  io_in_a_bits_param,
  input  logic [2:0]  io_in_a_bits_size,
  input  logic [1:0]  io_in_a_bits_source,
  input  logic [29:0] io_in_a_bits_address,
  input  logic        io_in_a_bits_mask,
  input  logic [7:0]  io_in_a_bits_data,

  input  logic        io_out_a_ready,
  output logic        io_out_a_valid,
  output logic [2:0]  io_out_a_bits_opcode,
  output logic [2:0]  io_out_a_bits_param,
  output logic [2:0]  io_out_a_bits_size,
  output logic [1:0]  io_out_a_bits_source,
  output logic [29:0] io_out_a_bits_address,
  output logic        io_out_a_bits_mask,
  output logic [7:0]  io_out_a_bits_data,

  output logic        io_out_d_ready,
  input  logic        io_out_d_valid,
  input  logic [2:0]  io_out_d_bits_opcode,
  input  logic [2:0]  io_out_d_bits_size,
  input  logic [1:0]  io_out_d_bits_source,
  input  logic [7:0]  io_out_d_bits_data,

  input  logic        io_in_d_ready,
  output logic        io_in_d_valid,
  output logic [2:0]  io_in_d_bits_opcode,
  output logic [2:0]  io_in_d_bits_size,
  output logic [1:0]  io_in_d_bits_source,
  output logic [7:0]  io_in_d_bits_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Index of the final fragment (N-1). Sizes of 6 and above saturate at 64 fragments.
  function automatic logic [5:0] lastOf(input logic [2:0] sz);
    logic [5:0] r;
    if (sz >= 3'd6) r = 6'd63;
    else            r = (6'd1 << sz) - 6'd1;
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  aCnt_q, aCnt_d;
  logic [5:0]  dCnt_q, dCnt_d;
  logic        isGet_q, isGet_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  source_q, source_d;

  logic        isIdle;
  logic        notDrain;
  logic        inIsGet;
  logic        curIsGet;
  logic [5:0]  curLast;
  logic        aFire;
  logic        aLast;
  logic        dFire;
  logic        dLast;
  logic        dForward;
  logic        unusedDBits;

  // The slave's size and source are replaced by the latched request values.
  assign unusedDBits = ^{io_out_d_bits_size, io_out_d_bits_source};

  // In IDLE the request type and fragment count come from the live bits.
  // Otherwise they come from the copy captured on the first fire.
  always_comb begin
    isIdle   = (state_q == IDLE);
    notDrain = (state_q != DRAIN);
    inIsGet  = (io_in_a_bits_opcode == 3'd4);
    curIsGet = isIdle ? inIsGet : isGet_q;
    curLast  = isIdle ? lastOf(io_in_a_bits_size) : lastOf(size_q);
    aFire    = io_in_a_valid & io_out_a_ready & notDrain;
    aLast    = (aCnt_q == curLast);
    dLast    = (dCnt_q == curLast);
    dForward = isGet_q | dLast;
  end

  // The A channel passes through, with the fragment index merged into the low address bits.
  always_comb begin
    io_out_a_valid        = io_in_a_valid & notDrain;
    io_in_a_ready         = io_out_a_ready & notDrain;
    io_repeat             = curIsGet & ~aLast;
    io_out_a_bits_opcode  = io_in_a_bits_opcode;
    io_out_a_bits_param   = io_in_a_bits_param;
    io_out_a_bits_size    = 3'd0;
    io_out_a_bits_source  = io_in_a_bits_source;
    io_out_a_bits_address = {io_in_a_bits_address[29:6], io_in_a_bits_address[5:0] | aCnt_q};
    io_out_a_bits_mask    = io_in_a_bits_mask;
    io_out_a_bits_data    = io_in_a_bits_data;
  end

  // The D channel is closed in IDLE. Dropped Put acks are sunk without being forwarded.
  always_comb begin
    io_in_d_bits_opcode = io_out_d_bits_opcode;
    io_in_d_bits_size   = size_q;
    io_in_d_bits_source = source_q;
    io_in_d_bits_data   = io_out_d_bits_data;
    if (isIdle) begin
      io_in_d_valid  = 1'b0;
      io_out_d_ready = 1'b0;
    end else if (dForward) begin
      io_in_d_valid  = io_out_d_valid;
      io_out_d_ready = io_in_d_ready;
    end else begin
      io_in_d_valid  = 1'b0;
      io_out_d_ready = 1'b1;
    end
    dFire = io_out_d_valid & io_out_d_ready;
  end

  // Next-state logic. A completed response burst overrides the fragment count and can end the transaction from SEND.
  always_comb begin
    state_d  = state_q;
    aCnt_d   = aCnt_q;
    dCnt_d   = dCnt_q;
    isGet_d  = isGet_q;
    size_d   = size_q;
    source_d = source_q;
    case (state_q)
      IDLE: begin
        if (aFire) begin
          isGet_d  = inIsGet;
          size_d   = io_in_a_bits_size;
          source_d = io_in_a_bits_source;
          if (curLast == 6'd0) begin
            state_d = DRAIN;
          end else begin
            state_d = SEND;
            aCnt_d  = 6'd1;
          end
        end
      end
      SEND: begin
        if (aFire) begin
          aCnt_d = aCnt_q + 6'd1;
          if (aLast) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (dFire) begin
      if (dLast) begin
        dCnt_d = 6'd0;
        aCnt_d = 6'd0;
        if ((state_q == DRAIN) || ((state_q == SEND) && aFire && aLast)) state_d = IDLE;
      end else begin
        dCnt_d = dCnt_q + 6'd1;
      end
    end
  end

  // State and counter registers. Reset returns to IDLE from any point in a transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      aCnt_q   <= 6'd0;
      dCnt_q   <= 6'd0;
      isGet_q  <= 1'b0;
      size_q   <= 3'd0;
      source_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      aCnt_q   <= aCnt_d;
      dCnt_q   <= dCnt_d;
      isGet_q  <= isGet_d;
      size_q   <= size_d;
      source_q <= source_d;
    end
  end

endmodule

// File: tb/tb_sirv_tl_frag_sequencer.sv
// Scoreboard bench for sirv_tl_frag_sequencer. The stimulus side pushes the
// expected out_a fragments and forwarded in_d beats. Independent monitors pop
// these entries and compare them against DUT traffic. A small slave model
// answers every fragment.
module tb_sirv_tl_frag_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_repeat;
  logic        io_in_a_ready;
  logic        io_in_a_valid = 1'b0;
  logic [2:0]  io_in_a_bits_opcode = 3'd0;
  logic [2:0]  io_in_a_bits_param = 3'd0;
  logic [2:0]  io_in_a_bits_size = 3'd0;
  logic [1:0]  io_in_a_bits_source = 2'd0;
  logic [29:0] io_in_a_bits_address = 30'd0;
  logic        io_in_a_bits_mask = 1'b1;
  logic [7:0]  io_in_a_bits_data = 8'd0;
  logic        io_out_a_ready = 1'b1;
  logic        io_out_a_valid;
  logic [2:0]  io_out_a_bits_opcode;
  logic [2:0]  io_out_a_bits_param;
  logic [2:0]  io_out_a_bits_size;
  logic [1:0]  io_out_a_bits_source;
  logic [29:0] io_out_a_bits_address;
  logic        io_out_a_bits_mask;
  logic [7:0]  io_out_a_bits_data;
  logic        io_out_d_ready;
  logic        io_out_d_valid = 1'b0;
  logic [2:0]  io_out_d_bits_opcode = 3'd0;
  logic [2:0]  io_out_d_bits_size = 3'd0;
  logic [1:0]  io_out_d_bits_source = 2'd0;
  logic [7:0]  io_out_d_bits_data = 8'd0;
  logic        io_in_d_ready = 1'b1;
  logic        io_in_d_valid;
  logic [2:0]  io_in_d_bits_opcode;
  logic [2:0]  io_in_d_bits_size;
  logic [1:0]  io_in_d_bits_source;
  logic [7:0]  io_in_d_bits_data;

  typedef struct {
    logic [29:0] addr;
    logic [7:0]  data;
    logic [2:0]  opcode;
    logic [1:0]  source;
    logic        rep;
  } expA_t;

  typedef struct {
    logic [2:0] opcode;
    logic [2:0] size;
    logic [1:0] source;
    logic [7:0] data;
  } expD_t;

  typedef struct {
    logic [2:0] opcode;
    logic [7:0] data;
  } rsp_t;

  expA_t expAQ[$];
  expD_t expDQ[$];
  rsp_t  slaveQ[$];

  int    checks = 0;
  int    failures = 0;
  logic  toggleA = 1'b0;
  int    dStall = 0;
  logic  dReadyBase = 1'b1;
  logic  strayValid = 1'b0;
  logic  slaveValid = 1'b0;
  logic  dFirePend = 1'b0;
  rsp_t  rspTmp;
  rsp_t  rspNew;
  expA_t monA;
  expD_t monD;
  int    firstWait;

  sirv_tl_frag_sequencer dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_repeat             (io_repeat),
    .io_in_a_ready         (io_in_a_ready),
    .io_in_a_valid         (io_in_a_valid),
    .io_in_a_bits_opcode   (io_in_a_bits_opcode),
    .io_in_a_bits_param    (io_in_a_bits_param),
    .io_in_a_bits_size     (io_in_a_bits_size),
    .io_in_a_bits_source   (io_in_a_bits_source),
    .io_in_a_bits_address  (io_in_a_bits_address),
    .io_in_a_bits_mask     (io_in_a_bits_mask),
    .io_in_a_bits_data     (io_in_a_bits_data),
    .io_out_a_ready        (io_out_a_ready),
    .io_out_a_valid        (io_out_a_valid),
    .io_out_a_bits_opcode  (io_out_a_bits_opcode),
    .io_out_a_bits_param   (io_out_a_bits_param),
    .io_out_a_bits_size    (io_out_a_bits_size),
    .io_out_a_bits_source  (io_out_a_bits_source),
    .io_out_a_bits_address (io_out_a_bits_address),
    .io_out_a_bits_mask    (io_out_a_bits_mask),
    .io_out_a_bits_data    (io_out_a_bits_data),
    .io_out_d_ready        (io_out_d_ready),
    .io_out_d_valid        (io_out_d_valid),
    .io_out_d_bits_opcode  (io_out_d_bits_opcode),
    .io_out_d_bits_size    (io_out_d_bits_size),
    .io_out_d_bits_source  (io_out_d_bits_source),
    .io_out_d_bits_data    (io_out_d_bits_data),
    .io_in_d_ready         (io_in_d_ready),
    .io_in_d_valid         (io_in_d_valid),
    .io_in_d_bits_opcode   (io_in_d_bits_opcode),
    .io_in_d_bits_size     (io_in_d_bits_size),
    .io_in_d_bits_source   (io_in_d_bits_source),
    .io_in_d_bits_data     (io_in_d_bits_data)
  );

  // Free-running clock with a 10-unit period.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Ready shaping. Drive out_a ready (constant or toggling) and in_d ready (with optional stall window).
  always @(negedge clock) begin
    io_out_a_ready <= toggleA ? ~io_out_a_ready : 1'b1;
    if (dStall > 0) begin
      io_in_d_ready <= 1'b0;
      dStall = dStall - 1;
    end else begin
      io_in_d_ready <= dReadyBase;
    end
  end

  // Slave model. Queue one response per accepted fragment and present the responses in order.
  always begin
    @(negedge clock);
    if (dFirePend && slaveQ.size() != 0) rspTmp = slaveQ.pop_front();
    dFirePend = 1'b0;
    if (slaveQ.size() != 0) begin
      slaveValid           = 1'b1;
      io_out_d_bits_opcode = slaveQ[0].opcode;
      io_out_d_bits_data   = slaveQ[0].data;
    end else begin
      slaveValid = 1'b0;
    end
    io_out_d_valid = slaveValid | strayValid;
    #2;
    if (reset) begin
      slaveQ.delete();
      slaveValid     = 1'b0;
      io_out_d_valid = strayValid;
    end else begin
      if (io_out_a_valid && io_out_a_ready) begin
        rspNew.opcode = (io_out_a_bits_opcode == 3'd4) ? 3'd1 : 3'd0;
        rspNew.data   = (io_out_a_bits_opcode == 3'd4) ? (io_out_a_bits_address[7:0] ^ 8'h5A) : 8'h00;
        slaveQ.push_back(rspNew);
      end
      dFirePend = slaveValid && io_out_d_ready;
    end
  end

  // Monitor. Compare every out_a fire and every forwarded in_d fire against the queued expectations.
  always begin
    @(negedge clock);
    #2;
    if (!reset && io_out_a_valid && io_out_a_ready) begin
      if (expAQ.size() == 0) begin
        checkOutput("unexpected_out_a_addr", {2'b0, io_out_a_bits_address}, 32'hFFFF_FFFF);
      end else begin
        monA = expAQ.pop_front();
        checkOutput("out_a_addr", {2'b0, io_out_a_bits_address}, {2'b0, monA.addr});
        checkOutput("out_a_size", {29'd0, io_out_a_bits_size}, 32'd0);
        checkOutput("out_a_data", {24'd0, io_out_a_bits_data}, {24'd0, monA.data});
        checkOutput("out_a_opcode", {29'd0, io_out_a_bits_opcode}, {29'd0, monA.opcode});
        checkOutput("out_a_source", {30'd0, io_out_a_bits_source}, {30'd0, monA.source});
        checkOutput("repeat", {31'd0, io_repeat}, {31'd0, monA.rep});
      end
    end
    if (!reset && io_in_d_valid && io_in_d_ready) begin
      if (expDQ.size() == 0) begin
        checkOutput("unexpected_in_d_data", {24'd0, io_in_d_bits_data}, 32'hFFFF_FFFF);
      end else begin
        monD = expDQ.pop_front();
        checkOutput("in_d_opcode", {29'd0, io_in_d_bits_opcode}, {29'd0, monD.opcode});
        checkOutput("in_d_size", {29'd0, io_in_d_bits_size}, {29'd0, monD.size});
        checkOutput("in_d_source", {30'd0, io_in_d_bits_source}, {30'd0, monD.source});
        checkOutput("in_d_data", {24'd0, io_in_d_bits_data}, {24'd0, monD.data});
      end
    end
  end

  // Issue one transaction. beats==0 means all fragments. A partial run queues no responses.
  task automatic applyStimulus(input logic [2:0] opcode, input logic [2:0] size, input logic [1:0] source,
                               input logic [29:0] addr, input logic [7:0] d0, input int beats,
                               output int waitFirst);
    int    n;
    int    nb;
    int    guard;
    logic  isGet;
    logic  fired;
    logic [29:0] fa;
    expA_t ea;
    expD_t ed;
    n     = 1 << ((size > 3'd6) ? 6 : int'(size));
    nb    = (beats == 0) ? n : beats;
    isGet = (opcode == 3'd4);
    waitFirst = 0;
    for (int i = 0; i < nb; i++) begin
      fa        = {addr[29:6], addr[5:0] | 6'(i)};
      ea.addr   = fa;
      ea.data   = isGet ? 8'h3C : (d0 + 8'(i) * 8'h11);
      ea.opcode = opcode;
      ea.source = source;
      ea.rep    = isGet && (i != n - 1);
      expAQ.push_back(ea);
      if (isGet && beats == 0) begin
        ed.opcode = 3'd1;
        ed.size   = size;
        ed.source = source;
        ed.data   = fa[7:0] ^ 8'h5A;
        expDQ.push_back(ed);
      end
    end
    if (!isGet && beats == 0) begin
      ed.opcode = 3'd0;
      ed.size   = size;
      ed.source = source;
      ed.data   = 8'h00;
      expDQ.push_back(ed);
    end
    for (int i = 0; i < nb; i++) begin
      io_in_a_bits_opcode  = opcode;
      io_in_a_bits_size    = size;
      io_in_a_bits_source  = source;
      io_in_a_bits_address = addr;
      io_in_a_bits_data    = isGet ? 8'h3C : (d0 + 8'(i) * 8'h11);
      io_in_a_valid        = 1'b1;
      guard = 0;
      fired = 1'b0;
      while (!fired && guard < 200) begin
        #3;
        fired = io_in_a_ready;
        @(negedge clock);
        if (!fired) guard++;
      end
      if (i == 0) waitFirst = guard;
      if (!fired) begin
        checkOutput("a_fire_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    io_in_a_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected beat has been observed and the slave is idle.
  task automatic waitDrain(input string name);
    int guard;
    guard = 0;
    while ((expAQ.size() != 0 || expDQ.size() != 0 || slaveQ.size() != 0) && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    checkOutput(name, {31'd0, (expAQ.size() == 0 && expDQ.size() == 0 && slaveQ.size() == 0)}, 32'd1);
    @(negedge clock);
  endtask

  // Watchdog against a hung DUT handshake.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #3;
    checkOutput("rst_repeat", {31'd0, io_repeat}, 32'd0);
    checkOutput("rst_in_d_valid", {31'd0, io_in_d_valid}, 32'd0);
    checkOutput("rst_out_d_ready", {31'd0, io_out_d_ready}, 32'd0);
    checkOutput("rst_in_a_ready", {31'd0, io_in_a_ready}, {31'd0, io_out_a_ready});
    checkOutput("rst_out_a_valid", {31'd0, io_out_a_valid}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // A stray slave response in IDLE must be neither consumed nor forwarded.
    strayValid = 1'b1;
    @(negedge clock);
    #3;
    checkOutput("stray_out_d_ready", {31'd0, io_out_d_ready}, 32'd0);
    checkOutput("stray_in_d_valid", {31'd0, io_in_d_valid}, 32'd0);
    @(negedge clock);
    strayValid = 1'b0;
    @(negedge clock);

    // Get, size 2, at 0x100.
    applyStimulus(3'd4, 3'd2, 2'd1, 30'h100, 8'h00, 0, firstWait);
    waitDrain("drain_get4");

    // Put, size 1, at 0x2, with data 0xAA and 0xBB.
    applyStimulus(3'd0, 3'd1, 2'd2, 30'h2, 8'hAA, 0, firstWait);
    waitDrain("drain_put2");

    // Single-fragment Get goes through DRAIN, where in_a_ready is held low.
    applyStimulus(3'd4, 3'd0, 2'd3, 30'h40, 8'h00, 0, firstWait);
    #3;
    checkOutput("get1_drain_in_a_ready", {31'd0, io_in_a_ready}, 32'd0);
    @(negedge clock);
    waitDrain("drain_get1");
    #3;
    checkOutput("get1_idle_in_a_ready", {31'd0, io_in_a_ready}, {31'd0, io_out_a_ready});
    @(negedge clock);

    // Get, size 7: 64 fragments.
    applyStimulus(3'd4, 3'd7, 2'd0, 30'h0001_2340, 8'h00, 0, firstWait);
    waitDrain("drain_get64");

    // Back-pressure on out_a ready and in_d ready.
    toggleA = 1'b1;
    dStall  = 4;
    applyStimulus(3'd4, 3'd2, 2'd2, 30'h204, 8'h00, 0, firstWait);
    waitDrain("drain_bp_get");
    applyStimulus(3'd1, 3'd2, 2'd1, 30'h3F0, 8'h10, 0, firstWait);
    waitDrain("drain_bp_put");
    toggleA = 1'b0;
    @(negedge clock);
    @(negedge clock);

    // Reset after 2 of 4 Get fragments, then an immediate Put.
    dReadyBase = 1'b0;
    @(negedge clock);
    applyStimulus(3'd4, 3'd2, 2'd3, 30'h300, 8'h00, 2, firstWait);
    reset = 1'b1;
    io_in_a_bits_opcode = 3'd0;
    io_in_a_bits_size   = 3'd1;
    #3;
    checkOutput("mid_rst_repeat", {31'd0, io_repeat}, 32'd0);
    checkOutput("mid_rst_in_d_valid", {31'd0, io_in_d_valid}, 32'd0);
    checkOutput("mid_rst_out_d_ready", {31'd0, io_out_d_ready}, 32'd0);
    checkOutput("mid_rst_in_a_ready", {31'd0, io_in_a_ready}, {31'd0, io_out_a_ready});
    checkOutput("mid_rst_frags_seen", 32'(expAQ.size()), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    dReadyBase = 1'b1;
    applyStimulus(3'd0, 3'd1, 2'd0, 30'h3A0, 8'h12, 0, firstWait);
    checkOutput("post_rst_put_first_wait", 32'(firstWait), 32'd0);
    waitDrain("drain_post_rst_put");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
